// File: rtl/adder72_seq_ctrl.sv
// Sequential 72-bit adder. One shared external adder24 slice is used over three
// cycles, low slice first, with the carry held in a register between slices.
module adder72_seq_ctrl #(
  parameter int unsigned SLICE_W    = 24,
  parameter int unsigned NUM_SLICES = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [SLICE_W*NUM_SLICES-1:0]   a,
  input  logic [SLICE_W*NUM_SLICES-1:0]   b,
  input  logic                            cin,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [SLICE_W*NUM_SLICES-1:0]   sum,
  output logic                            cout,
  output logic [SLICE_W-1:0]              sl_a,
  output logic [SLICE_W-1:0]              sl_b,
  output logic                            sl_cin,
  input  logic [SLICE_W-1:0]              sl_s,
  input  logic                            sl_cout
);

  localparam int unsigned W    = SLICE_W * NUM_SLICES;
  localparam int unsigned IW   = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_SLICES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [W-1:0]  sum_reg;
  logic          carry;
  logic          cout_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      sum_reg  <= '0;
      carry    <= 1'b0;
      cout_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b;
            carry <= cin;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          // Slices not yet written keep the previous result until overwritten.
          sum_reg[idx*SLICE_W +: SLICE_W] <= sl_s;
          carry <= sl_cout;
          if (idx == LAST) begin
            cout_reg <= sl_cout;
            idx      <= '0;
            state    <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    sl_a   = '0;
    sl_b   = '0;
    sl_cin = 1'b0;
    if (state == RUN) begin
      sl_a   = a_reg[idx*SLICE_W +: SLICE_W];
      sl_b   = b_reg[idx*SLICE_W +: SLICE_W];
      sl_cin = carry;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_reg;
  assign cout      = cout_reg;

endmodule
